skeeball_sensor_front: RTL

//  Front end feeding the skeeball score accumulator: conditions the seven raw hole-sensor

---
 rtl/skeeball_sensor_front_if.sv | 29 ++
 rtl/skeeball_sensor_front.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/skeeball_sensor_front_if.sv
// Signal bundle between the skeeball cabinet sensors and the score-side logic.
// The master drives the raw switches; the slave (sensor front end) returns clean pulses and game status.
interface skeeball_sensor_front_if;
    logic       start_btn;
    logic [6:0] raw_hole;
    logic       start;
    logic       in0;
    logic       in10;
    logic       in20;
    logic       in30;
    logic       in40;
    logic       in50;
    logic       in100;
    logic [3:0] ball_count;
    logic       playing;
    logic       game_over;

    modport master (
        output start_btn, raw_hole,
        input  start, in0, in10, in20, in30, in40, in50, in100,
        input  ball_count, playing, game_over
    );

    modport slave (
        input  start_btn, raw_hole,
        output start, in0, in10, in20, in30, in40, in50, in100,
        output ball_count, playing, game_over
    );
endinterface

// File: rtl/skeeball_sensor_front.sv
// Skeeball sensor front end: synchronizes and debounces the start button and seven hole
// switches, then sequences the game and emits one-clock hole and start pulses.
module skeeball_sensor_front #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 32,
    parameter int unsigned BALLS_PER_GAME  = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    skeeball_sensor_front_if.slave  bus
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
    localparam logic [3:0]    BALLS     = 4'(BALLS_PER_GAME);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    // Channel 7 is the start button, channels 6..0 are the holes.
    logic [7:0]    raw;
    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    level;
    logic [7:0]    level_d;
    logic [7:0]    rise;
    logic [DW-1:0] db_cnt [8];

    logic          start_rise;
    logic [6:0]    hole_rise;
    logic [6:0]    pick;

    state_t        state;
    logic [LW-1:0] lockout;
    logic [6:0]    hole_pulse;
    logic          start_q;
    logic [3:0]    ball_count_q;
    logic          playing_q;
    logic          game_over_q;

    assign raw = {bus.start_btn, bus.raw_hole};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int unsigned i = 0; i < 8; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= ~level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The edge is held for one cycle by level_d; the FSM registers it into its outputs.
    assign rise       = level & ~level_d;
    assign start_rise = rise[7];
    assign hole_rise  = rise[6:0];

    // Highest-value hole wins when several rise together.
    always_comb begin
        pick = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (hole_rise[i]) begin
                pick = 7'(1) << i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lockout      <= '0;
            hole_pulse   <= '0;
            start_q      <= 1'b0;
            ball_count_q <= '0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            hole_pulse <= '0;
            if (lockout != '0) begin
                lockout <= lockout - 1'b1;
            end
            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state        <= PLAY;
                        start_q      <= 1'b1;
                        ball_count_q <= '0;
                        lockout      <= '0;
                        playing_q    <= 1'b1;
                        game_over_q  <= 1'b0;
                    end
                end
                PLAY: begin
                    if ((hole_rise != '0) && (lockout == '0)) begin
                        hole_pulse <= pick;
                        lockout    <= LOCK_LOAD;
                        if (ball_count_q != BALLS) begin
                            ball_count_q <= ball_count_q + 4'd1;
                        end
                        if (ball_count_q + 4'd1 == BALLS) begin
                            state       <= OVER;
                            playing_q   <= 1'b0;
                            game_over_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start      = start_q;
    assign bus.in0        = hole_pulse[0];
    assign bus.in10       = hole_pulse[1];
    assign bus.in20       = hole_pulse[2];
    assign bus.in30       = hole_pulse[3];
    assign bus.in40       = hole_pulse[4];
    assign bus.in50       = hole_pulse[5];
    assign bus.in100      = hole_pulse[6];
    assign bus.ball_count = ball_count_q;
    assign bus.playing    = playing_q;
    assign bus.game_over  = game_over_q;
endmodule
